chip_select_unit: RTL and testbench
===================================

CHIP_SELECT_UNIT -- requirements
Module: chip_select_unit

Interface
REQ-001 Parameters SHALL be: ADDR_W, 22, address bus width; SLOT_BITS, 4, peripheral slot size log2 (legal 4 or 5); WS_W, 4, wait-state register width; DEFAULT_WS, 2, reset wait count of every channel.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-003 Derived constant N_PERIPH SHALL equal 2**(7-SLOT_BITS), giving 8 at SLOT_BITS=4 and 4 at SLOT_BITS=5.
REQ-004 Ports SHALL be:
- clk  in  1  system clock
- arst  in  1  async reset, active-high
- address_bus  in  ADDR_W  CPU address
- mem_io  in  1  1 = memory space
- rd  in  1  read strobe, active-low
- wr  in  1  write strobe, active-low
- data_in  in  8  CPU write data
- rom_cs_n  out  1  BIOS ROM select, active-low
- ram_cs_n  out  1  BIOS RAM select, active-low
- periph_cs_n  out  N_PERIPH  peripheral selects, active-low
- pin_wait  out  1  CPU wait request, active-high
- data_out  out  8  config readback
- data_oe  out  1  data_out drive enable

Function
REQ-005 real = mem_io & ~|address_bus[ADDR_W-1:16]; top = &address_bus[15:7].
REQ-006 rom_cs_n SHALL be low iff real & !address_bus[15].
REQ-007 ram_cs_n SHALL be low iff real & address_bus[15] & !top.
REQ-008 periph_cs_n[k] SHALL be low iff real & top & address_bus[6:SLOT_BITS]==k.
REQ-009 Slot N_PERIPH-1 SHALL be the config slot; its offset o=address_bus[SLOT_BITS-1:0] addresses wait registers: o<N_PERIPH selects ws_p[o], o==N_PERIPH selects ws_rom, o==N_PERIPH+1 selects ws_ram, all other offsets are unmapped.
REQ-010 Chip selects SHALL be combinational from the address and SHALL not depend on rd/wr.
REQ-011 strobe = !rd | !wr; start SHALL be strobe high while the registered strobe is low.
REQ-012 On start, the channel SHALL be latched from the current decode; address changes before strobe release SHALL be ignored.
REQ-013 ws_sel SHALL be the latched channel's register; ws_sel SHALL be 0 for the config slot and for unmapped or I/O accesses.
REQ-014 FSM states SHALL be IDLE, WAIT and HOLD.
- IDLE: on start with ws_sel>0, load count=ws_sel-1 and go to WAIT if count>0, otherwise HOLD; on start with ws_sel=0, go to HOLD.
- WAIT: decrement count; when count reaches 0, go to HOLD.
- HOLD: go to IDLE when strobe is low.
REQ-015 pin_wait SHALL be (start & ws_sel!=0) | (state==WAIT), giving exactly ws_sel high cycles beginning in the start cycle.
REQ-016 If strobe deasserts during WAIT, the FSM SHALL go to IDLE and pin_wait SHALL be low from the next cycle.
REQ-017 Config write: while wr is low, data_in SHALL be sampled every cycle; on the cycle wr rises, the latched config register SHALL be written with the last sample [WS_W-1:0]; unmapped offsets SHALL be ignored.
REQ-018 If rd and wr are both low, the access SHALL be treated as a write.
REQ-019 data_oe SHALL be !rd & wr & config-slot decode; data_out SHALL be the addressed register zero-extended, or 0 for unmapped offsets.

Reset
REQ-020 While arst is high: state = IDLE, count = 0, pin_wait = 0, registered strobe = 0, all ws = DEFAULT_WS, all cs_n = 1, data_oe = 0.
REQ-021 Reset during WAIT SHALL abort the access with no register write.

Structure
REQ-022 Package pa_bus SHALL hold the FSM state enum, the real-mode boundary constant (16) and the peripheral window constants (bits 15:7).
REQ-023 Sub-module cs_wait_timer SHALL contain the FSM, the counter and pin_wait; decode and registers SHALL remain in chip_select_unit.

Verification
REQ-024 After reset, read address 0x0000 with mem_io=1 -> rom_cs_n=0 and pin_wait high for 2 cycles starting at the rd fall.
REQ-025 Write 0x05 to 0xFFF0 (ws_p[0]), then read 0xFF80 -> periph_cs_n=8'hFE and pin_wait high for 5 cycles.
REQ-026 Write 0x00 to 0xFFF9 (ws_ram), then read 0x8000 -> ram_cs_n=0 and pin_wait never asserts.
REQ-027 Read 0xFFF8 after reset -> data_oe=1 and data_out=0x02; read 0xFFFC -> data_out=0x00.
REQ-028 Set ws_p[3]=0xF, access 0xFFB0, release rd after 4 cycles -> pin_wait low on the next cycle and FSM in IDLE.
REQ-029 Assert arst during WAIT -> pin_wait=0 immediately and all ws registers read back 0x02.

Source files
------------

// File: rtl/pa_bus.sv
// pa_bus: shared FSM state type and address-window constants for the chip-select unit.
package pa_bus;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  localparam int REAL_TOP = 16;
  localparam int WIN_HI = 15;
  localparam int WIN_LO = 7;
  localparam int CH_W = 4;
endpackage

// File: rtl/cs_wait_timer.sv
// cs_wait_timer: per-access wait-state sequencer driving the CPU wait request.
module cs_wait_timer
  import pa_bus::*;
#(
  parameter int WS_W = 4
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            start,
  input  logic            strobe,
  input  logic [WS_W-1:0] ws_sel,
  output logic            pin_wait
);
  state_t state, state_n;
  logic [WS_W-1:0] count, count_n;
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  always_comb begin
    state_n = state;
    count_n = count;
    case (state)
      IDLE: if (start) begin
        count_n = ws_sel == '0 ? '0 : ws_sel - WS_W'(1);
        state_n = ws_sel > WS_W'(1) ? WAIT : HOLD;
      end
      WAIT: if (!strobe) state_n = IDLE;
        else begin
          count_n = count - WS_W'(1);
          state_n = count == WS_W'(1) ? HOLD : WAIT;
        end
      HOLD: if (!strobe) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // the start cycle itself already counts as the first wait cycle
  assign pin_wait = (start & |ws_sel) | (state == WAIT);
endmodule

// File: rtl/chip_select_unit.sv
// chip_select_unit: real-mode address decode into ROM/RAM/peripheral selects with
// programmable per-channel wait states held in a config slot.
module chip_select_unit
  import pa_bus::*;
#(
  parameter int ADDR_W     = 22,
  parameter int SLOT_BITS  = 4,
  parameter int WS_W       = 4,
  parameter int DEFAULT_WS = 2,
  localparam int N_PERIPH  = 2 ** (7 - SLOT_BITS)
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [ADDR_W-1:0]   address_bus,
  input  logic                mem_io,
  input  logic                rd,
  input  logic                wr,
  input  logic [7:0]          data_in,
  output logic                rom_cs_n,
  output logic                ram_cs_n,
  output logic [N_PERIPH-1:0] periph_cs_n,
  output logic                pin_wait,
  output logic [7:0]          data_out,
  output logic                data_oe
);
  localparam int SW = 7 - SLOT_BITS;
  localparam int NREG = N_PERIPH + 2;
  localparam logic [CH_W-1:0] CH_ROM = CH_W'(N_PERIPH);
  localparam logic [CH_W-1:0] CH_RAM = CH_W'(N_PERIPH + 1);
  localparam logic [CH_W-1:0] CH_NONE = CH_W'(N_PERIPH + 2);
  logic real_mode, win_top, cfg_hit, ofs_ok, strobe, strobe_q, start, wr_q, cfg_ok_q;
  logic [SW-1:0] slot;
  logic [SLOT_BITS-1:0] ofs, cfg_idx_q;
  logic [CH_W-1:0] cur_ch, ch_q, sel_ch;
  logic [WS_W-1:0] ws [NREG];
  logic [WS_W-1:0] wdata, ws_sel;
  assign real_mode = mem_io & ~|address_bus[ADDR_W-1:REAL_TOP];
  assign win_top = &address_bus[WIN_HI:WIN_LO];
  assign slot = address_bus[6:SLOT_BITS];
  assign ofs = address_bus[SLOT_BITS-1:0];
  assign cfg_hit = real_mode & win_top & (slot == SW'(N_PERIPH - 1));
  assign ofs_ok = ofs < SLOT_BITS'(NREG);
  assign rom_cs_n = !(real_mode & !address_bus[15] & !arst);
  assign ram_cs_n = !(real_mode & address_bus[15] & !win_top & !arst);
  for (genvar k = 0; k < N_PERIPH; k++) begin : g_pcs
    assign periph_cs_n[k] = !(real_mode & win_top & (slot == SW'(k)) & !arst);
  end
  // register index equals channel code: peripherals first, then ROM, then RAM
  assign cur_ch = !real_mode ? CH_NONE : !address_bus[15] ? CH_ROM : !win_top ? CH_RAM :
                  cfg_hit ? CH_NONE : CH_W'(slot);
  assign strobe = !rd | !wr;
  assign start = strobe & !strobe_q & !arst;
  assign sel_ch = start ? cur_ch : ch_q;
  assign ws_sel = sel_ch == CH_NONE ? '0 : ws[sel_ch];
  assign data_oe = !rd & wr & cfg_hit & !arst;
  assign data_out = cfg_hit & ofs_ok ? 8'(ws[ofs]) : 8'h00;
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      strobe_q <= 1'b0;
      wr_q <= 1'b1;
      wdata <= '0;
      ch_q <= CH_NONE;
      cfg_ok_q <= 1'b0;
      cfg_idx_q <= '0;
      for (int i = 0; i < NREG; i++) ws[i] <= WS_W'(DEFAULT_WS);
    end else begin
      strobe_q <= strobe;
      wr_q <= wr;
      if (!wr) wdata <= data_in[WS_W-1:0];
      if (start) begin
        ch_q <= cur_ch;
        cfg_ok_q <= cfg_hit & ofs_ok;
        cfg_idx_q <= ofs;
      end
      if (wr & !wr_q & cfg_ok_q) ws[cfg_idx_q] <= wdata;
    end
  cs_wait_timer #(.WS_W(WS_W)) u_timer (
    .clk(clk), .arst(arst), .start(start), .strobe(strobe), .ws_sel(ws_sel), .pin_wait(pin_wait)
  );
endmodule

// File: tb/tb_chip_select_unit.sv
// tb_chip_select_unit: decode vector table plus wait-state access sequences checked against a pin-count scoreboard.
module tb_chip_select_unit;
  import pa_bus::*;
  logic clk = 0, arst = 1, mem_io = 1, rd = 1, wr = 1;
  logic [21:0] address_bus = '0;
  logic [7:0] data_in = '0, periph_cs_n, data_out;
  logic rom_cs_n, ram_cs_n, pin_wait, data_oe;
  int total = 0, bad = 0;
  int exp_q[$];
  typedef struct {
    logic [21:0] a;
    logic m, r, rom, ram;
    logic [7:0] per;
    logic oe;
    logic [7:0] dout;
  } vec_t;
  vec_t tbl[13];

  chip_select_unit dut (
    .clk(clk), .arst(arst), .address_bus(address_bus), .mem_io(mem_io), .rd(rd), .wr(wr),
    .data_in(data_in), .rom_cs_n(rom_cs_n), .ram_cs_n(ram_cs_n), .periph_cs_n(periph_cs_n),
    .pin_wait(pin_wait), .data_out(data_out), .data_oe(data_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic access(input logic [21:0] a, input logic w, input logic [7:0] d, input int exp_pins, input string nm);
    int pins = 0;
    exp_q.push_back(exp_pins);
    @(posedge clk); #1;
    address_bus = a; mem_io = 1; data_in = d;
    if (w) wr = 0; else rd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pin_wait) pins++;
    end
    @(posedge clk); #1;
    rd = 1; wr = 1;
    repeat (2) @(posedge clk);
    chk(nm, pins, exp_q.pop_front());
  endtask

  task automatic readback(input logic [21:0] a, input int exp, input string nm);
    @(posedge clk); #1;
    address_bus = a; mem_io = 1; rd = 0;
    @(negedge clk);
    chk({nm, "_oe"}, data_oe, 1);
    chk(nm, data_out, exp);
    @(posedge clk); #1;
    rd = 1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int pins;
    tbl[0]  = '{22'h000000, 1, 1, 0, 1, 8'hFF, 0, 8'h00};
    tbl[1]  = '{22'h007FFF, 1, 1, 0, 1, 8'hFF, 0, 8'h00};
    tbl[2]  = '{22'h008000, 1, 1, 1, 0, 8'hFF, 0, 8'h00};
    tbl[3]  = '{22'h00FF7F, 1, 1, 1, 0, 8'hFF, 0, 8'h00};
    tbl[4]  = '{22'h00FF80, 1, 1, 1, 1, 8'hFE, 0, 8'h00};
    tbl[5]  = '{22'h00FFB0, 1, 1, 1, 1, 8'hF7, 0, 8'h00};
    tbl[6]  = '{22'h00FFF0, 1, 1, 1, 1, 8'h7F, 0, 8'h02};
    tbl[7]  = '{22'h000000, 0, 1, 1, 1, 8'hFF, 0, 8'h00};
    tbl[8]  = '{22'h010000, 1, 1, 1, 1, 8'hFF, 0, 8'h00};
    tbl[9]  = '{22'h00FFF8, 1, 0, 1, 1, 8'h7F, 1, 8'h02};
    tbl[10] = '{22'h00FFFC, 1, 0, 1, 1, 8'h7F, 1, 8'h00};
    tbl[11] = '{22'h00FFF9, 0, 0, 1, 1, 8'hFF, 0, 8'h00};
    tbl[12] = '{22'h00FF80, 1, 0, 1, 1, 8'hFE, 0, 8'h00};

    #12;
    chk("rst_rom_cs", rom_cs_n, 1);
    chk("rst_pin_wait", pin_wait, 0);
    chk("rst_state", dut.u_timer.state, IDLE);
    @(posedge clk); #1;
    arst = 0;

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      address_bus = tbl[i].a; mem_io = tbl[i].m; rd = tbl[i].r;
      @(negedge clk);
      chk($sformatf("v%0d_rom", i), rom_cs_n, tbl[i].rom);
      chk($sformatf("v%0d_ram", i), ram_cs_n, tbl[i].ram);
      chk($sformatf("v%0d_per", i), periph_cs_n, tbl[i].per);
      chk($sformatf("v%0d_oe", i), data_oe, tbl[i].oe);
      chk($sformatf("v%0d_dout", i), data_out, tbl[i].dout);
      @(posedge clk); #1;
      rd = 1;
      repeat (3) @(posedge clk);
    end

    access(22'h0000, 0, 8'h00, 2, "rom_read_wait");
    access(22'hFFF0, 1, 8'h05, 0, "cfg_write_p0");
    readback(22'hFFF0, 5, "rb_p0");
    access(22'hFF80, 0, 8'h00, 5, "p0_read_wait");
    access(22'hFFF9, 1, 8'h00, 0, "cfg_write_ram");
    readback(22'hFFF9, 0, "rb_ram");
    access(22'h8000, 0, 8'h00, 0, "ram_read_nowait");
    access(22'hFFFC, 1, 8'h07, 0, "cfg_write_unmapped");
    readback(22'hFFF8, 2, "rb_rom_untouched");
    access(22'hFFF3, 1, 8'hAF, 0, "cfg_write_p3");
    readback(22'hFFF3, 15, "rb_p3");

    // early strobe release in the middle of a long wait
    exp_q.push_back(4);
    pins = 0;
    @(posedge clk); #1;
    address_bus = 22'hFFB0; rd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pin_wait) pins++;
    end
    @(posedge clk); #1;
    rd = 1;
    @(negedge clk);
    @(negedge clk);
    chk("release_pins", pins, exp_q.pop_front());
    chk("release_pin_low", pin_wait, 0);
    chk("release_idle", dut.u_timer.state, IDLE);
    repeat (2) @(posedge clk);

    // reset in the middle of a wait
    @(posedge clk); #1;
    address_bus = 22'hFF80; rd = 0;
    @(negedge clk);
    chk("pre_rst_wait", pin_wait, 1);
    @(posedge clk); #1;
    arst = 1;
    #1;
    chk("arst_pin_wait", pin_wait, 0);
    chk("arst_state", dut.u_timer.state, IDLE);
    chk("arst_per_cs", periph_cs_n, 8'hFF);
    @(posedge clk); #1;
    rd = 1;
    @(posedge clk); #1;
    arst = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) readback(22'hFFF0 + 22'(i), 2, $sformatf("post_rst_ws%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
